// File: rtl/forwarding_ctrl.sv
// -----------------------------------------------------------------------------
// forwarding_ctrl
//
// Operand-forwarding and load-use stall controller for the execute pipeline.
// Both p2 operand read ports are compared against the destinations of STAGES
// downstream stages (index 0 = p3, the youngest). The youngest enabled match
// supplies the forwarded data. A match against a loading p3 freezes p2 for
// LOAD_STALL cycles. All state and outputs update on the falling clock edge.
//
// Ports
//   clock           in   pipeline clock, state updates on the falling edge
//   reset_n         in   asynchronous active-low reset
//   flush           in   synchronous, abandons any stall and clears outputs
//   read_addr_A/B   in   p2 operand register addresses
//   read_en_A/B     in   operand is actually used by the p2 instruction
//   write_addr_bus  in   per-stage destination address, stage i at [i*ADDR_W +: ADDR_W]
//   write_data_bus  in   per-stage result data, stage i at [i*DATA_W +: DATA_W]
//   write_en        in   per-stage write enable
//   load_p3         in   p3 holds a load whose data is not yet available
//   fwd_data_A/B    out  forwarded operand data
//   fwd_en_A/B      out  use fwd_data instead of the register file
//   fwd_src_A/B     out  index of the selected stage (0 when not forwarding)
//   stall_p2        out  hold p2 and PC, inject a bubble into p3
// -----------------------------------------------------------------------------
module forwarding_ctrl #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 3,
   parameter int STAGES     = 3,
   parameter int LOAD_STALL = 1,
   parameter int ZERO_REG   = 0
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic [ADDR_W-1:0]          read_addr_A,
   input  logic [ADDR_W-1:0]          read_addr_B,
   input  logic                       read_en_A,
   input  logic                       read_en_B,
   input  logic [STAGES*ADDR_W-1:0]   write_addr_bus,
   input  logic [STAGES*DATA_W-1:0]   write_data_bus,
   input  logic [STAGES-1:0]          write_en,
   input  logic                       load_p3,
   output logic [DATA_W-1:0]          fwd_data_A,
   output logic [DATA_W-1:0]          fwd_data_B,
   output logic                       fwd_en_A,
   output logic                       fwd_en_B,
   output logic [2:0]                 fwd_src_A,
   output logic [2:0]                 fwd_src_B,
   output logic                       stall_p2
);

   typedef enum logic {RUN, STALL} state_t;

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;

   // Per-stage match vectors for each port
   logic [STAGES-1:0] match_a, match_b;
   logic              addr_ok_a, addr_ok_b;

   // With a hard-wired zero register, address 0 never matches anything
   assign addr_ok_a = (ZERO_REG == 0) || (read_addr_A != '0);
   assign addr_ok_b = (ZERO_REG == 0) || (read_addr_B != '0);

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_match
         assign match_a[gi] = read_en_A & write_en[gi] & addr_ok_a &
                              (read_addr_A == write_addr_bus[gi*ADDR_W +: ADDR_W]);
         assign match_b[gi] = read_en_B & write_en[gi] & addr_ok_b &
                              (read_addr_B == write_addr_bus[gi*ADDR_W +: ADDR_W]);
      end
   endgenerate

   // Priority select: scanning from oldest to youngest, so the last
   // assignment (lowest index, youngest stage) wins.
   logic              sel_en_a, sel_en_b;
   logic [2:0]        sel_src_a, sel_src_b;
   logic [DATA_W-1:0] sel_data_a, sel_data_b;

   always_comb begin
      sel_en_a   = 1'b0;
      sel_src_a  = 3'd0;
      sel_data_a = '0;
      sel_en_b   = 1'b0;
      sel_src_b  = 3'd0;
      sel_data_b = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         if (match_a[i]) begin
            sel_en_a   = 1'b1;
            sel_src_a  = 3'(i);
            sel_data_a = write_data_bus[i*DATA_W +: DATA_W];
         end
         if (match_b[i]) begin
            sel_en_b   = 1'b1;
            sel_src_b  = 3'(i);
            sel_data_b = write_data_bus[i*DATA_W +: DATA_W];
         end
      end
   end

   // A stage-0 match on a load cannot be forwarded yet, regardless of any
   // older-stage match.
   logic hazard;
   assign hazard = (match_a[0] | match_b[0]) & load_p3;

   // Next-state / next-output logic
   logic              stall_next;
   logic              en_a_next, en_b_next;
   logic [2:0]        src_a_next, src_b_next;
   logic [DATA_W-1:0] data_a_next, data_b_next;
   logic              evaluate;

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      stall_next  = 1'b0;
      en_a_next   = 1'b0;
      en_b_next   = 1'b0;
      src_a_next  = 3'd0;
      src_b_next  = 3'd0;
      data_a_next = '0;
      data_b_next = '0;
      evaluate    = 1'b0;

      if (flush) begin
         state_next = RUN;
         cnt_next   = 4'd0;
      end else begin
         case (state)
            RUN: evaluate = 1'b1;
            STALL: begin
               if (cnt != 4'd0) begin
                  cnt_next   = cnt - 4'd1;
                  stall_next = 1'b1;
               end else begin
                  // Stall expires: this same edge performs a normal evaluation
                  evaluate = 1'b1;
               end
            end
            default: state_next = RUN;
         endcase

         if (evaluate) begin
            if (hazard) begin
               // The hazard edge itself counts as the first stall cycle
               state_next = STALL;
               cnt_next   = 4'(LOAD_STALL - 1);
               stall_next = 1'b1;
            end else begin
               state_next  = RUN;
               cnt_next    = 4'd0;
               en_a_next   = sel_en_a;
               en_b_next   = sel_en_b;
               src_a_next  = sel_src_a;
               src_b_next  = sel_src_b;
               data_a_next = sel_data_a;
               data_b_next = sel_data_b;
            end
         end
      end
   end

   // State and registered outputs, falling-edge clocked
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RUN;
         cnt        <= 4'd0;
         stall_p2   <= 1'b0;
         fwd_en_A   <= 1'b0;
         fwd_en_B   <= 1'b0;
         fwd_src_A  <= 3'd0;
         fwd_src_B  <= 3'd0;
         fwd_data_A <= '0;
         fwd_data_B <= '0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         stall_p2   <= stall_next;
         fwd_en_A   <= en_a_next;
         fwd_en_B   <= en_b_next;
         fwd_src_A  <= src_a_next;
         fwd_src_B  <= src_b_next;
         fwd_data_A <= data_a_next;
         fwd_data_B <= data_b_next;
      end
   end

endmodule

// File: tb/tb_forwarding_ctrl.sv
// -----------------------------------------------------------------------------
// tb_forwarding_ctrl
//
// Directed bench for forwarding_ctrl. Two instances share one stimulus set:
//   dut_a : LOAD_STALL=2, ZERO_REG=0
//   dut_b : LOAD_STALL=3, ZERO_REG=1
// Inputs change 1 time unit after a falling edge; outputs are sampled 1 time
// unit after the following falling edge.
// Observation vector per instance:
//   {stall_p2, fwd_en_A, fwd_src_A, fwd_data_A, fwd_en_B, fwd_src_B, fwd_data_B}
// -----------------------------------------------------------------------------
module tb_forwarding_ctrl;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int ST = 3;

   logic            clock;
   logic            reset_n;
   logic            flush;
   logic [AW-1:0]   read_addr_A, read_addr_B;
   logic            read_en_A, read_en_B;
   logic [ST*AW-1:0] write_addr_bus;
   logic [ST*DW-1:0] write_data_bus;
   logic [ST-1:0]   write_en;
   logic            load_p3;

   logic [DW-1:0]   a_data_A, a_data_B, b_data_A, b_data_B;
   logic            a_en_A, a_en_B, b_en_A, b_en_B;
   logic [2:0]      a_src_A, a_src_B, b_src_A, b_src_B;
   logic            a_stall, b_stall;

   int checks = 0;
   int errors = 0;

   forwarding_ctrl #(.DATA_W(DW), .ADDR_W(AW), .STAGES(ST), .LOAD_STALL(2), .ZERO_REG(0)) dut_a (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .read_addr_A(read_addr_A), .read_addr_B(read_addr_B),
      .read_en_A(read_en_A), .read_en_B(read_en_B),
      .write_addr_bus(write_addr_bus), .write_data_bus(write_data_bus),
      .write_en(write_en), .load_p3(load_p3),
      .fwd_data_A(a_data_A), .fwd_data_B(a_data_B),
      .fwd_en_A(a_en_A), .fwd_en_B(a_en_B),
      .fwd_src_A(a_src_A), .fwd_src_B(a_src_B),
      .stall_p2(a_stall)
   );

   forwarding_ctrl #(.DATA_W(DW), .ADDR_W(AW), .STAGES(ST), .LOAD_STALL(3), .ZERO_REG(1)) dut_b (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .read_addr_A(read_addr_A), .read_addr_B(read_addr_B),
      .read_en_A(read_en_A), .read_en_B(read_en_B),
      .write_addr_bus(write_addr_bus), .write_data_bus(write_data_bus),
      .write_en(write_en), .load_p3(load_p3),
      .fwd_data_A(b_data_A), .fwd_data_B(b_data_B),
      .fwd_en_A(b_en_A), .fwd_en_B(b_en_B),
      .fwd_src_A(b_src_A), .fwd_src_B(b_src_B),
      .stall_p2(b_stall)
   );

   wire [40:0] obs_a = {a_stall, a_en_A, a_src_A, a_data_A, a_en_B, a_src_B, a_data_B};
   wire [40:0] obs_b = {b_stall, b_en_A, b_src_A, b_data_A, b_en_B, b_src_B, b_data_B};

   initial clock = 1'b1;
   always #5 clock = ~clock;

   task automatic clear_inputs();
      flush          = 1'b0;
      read_addr_A    = '0;
      read_addr_B    = '0;
      read_en_A      = 1'b0;
      read_en_B      = 1'b0;
      write_addr_bus = '0;
      write_data_bus = '0;
      write_en       = '0;
      load_p3        = 1'b0;
   endtask

   task automatic set_stage(input int i, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic en);
      write_addr_bus[i*AW +: AW] = addr;
      write_data_bus[i*DW +: DW] = data;
      write_en[i]                = en;
   endtask

   task automatic edge_n();
      @(negedge clock);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      read_addr_A = 3'd1;
      read_en_A   = 1'b1;
      set_stage(0, 3'd1, 16'h1234, 1'b1);
      load_p3     = 1'b1;
      edge_n();
      edge_n();
      checks++;
      if (obs_a !== 41'h0) begin
         $display("FAIL reset_a: got %h expected %h", obs_a, 41'h0);
         errors++;
      end else $display("pass reset_a obs=%h", obs_a);
      checks++;
      if (obs_b !== 41'h0) begin
         $display("FAIL reset_b: got %h expected %h", obs_b, 41'h0);
         errors++;
      end else $display("pass reset_b obs=%h", obs_b);
      clear_inputs();
      reset_n = 1'b1;
   endtask

   task automatic test_defaults();
      logic [40:0] exp;
      clear_inputs();
      read_addr_A = 3'd3;
      read_en_A   = 1'b1;
      set_stage(0, 3'd3, 16'h1111, 1'b1);
      set_stage(1, 3'd3, 16'h2222, 1'b1);
      set_stage(2, 3'd3, 16'h3333, 1'b0);
      edge_n();
      exp = {1'b0, 1'b1, 3'd0, 16'h1111, 1'b0, 3'd0, 16'h0000};
      checks++;
      if (obs_a !== exp) begin
         $display("FAIL defaults_youngest_a: got %h expected %h", obs_a, exp);
         errors++;
      end else $display("pass defaults_youngest_a obs=%h", obs_a);
      checks++;
      if (obs_b !== exp) begin
         $display("FAIL defaults_youngest_b: got %h expected %h", obs_b, exp);
         errors++;
      end else $display("pass defaults_youngest_b obs=%h", obs_b);

      // p3 no longer writing: p4 takes over
      write_en[0] = 1'b0;
      edge_n();
      exp = {1'b0, 1'b1, 3'd1, 16'h2222, 1'b0, 3'd0, 16'h0000};
      checks++;
      if (obs_a !== exp) begin
         $display("FAIL defaults_p4: got %h expected %h", obs_a, exp);
         errors++;
      end else $display("pass defaults_p4 obs=%h", obs_a);
   endtask

   task automatic test_we_gating();
      logic [40:0] exp;
      clear_inputs();
      read_addr_B = 3'd5;
      read_en_B   = 1'b1;
      set_stage(0, 3'd5, 16'h1234, 1'b0);
      set_stage(1, 3'd2, 16'h2222, 1'b1);
      set_stage(2, 3'd5, 16'hBEEF, 1'b1);
      edge_n();
      exp = {1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 16'hBEEF};
      checks++;
      if (obs_a !== exp) begin
         $display("FAIL we_gating_p5_a: got %h expected %h", obs_a, exp);
         errors++;
      end else $display("pass we_gating_p5_a obs=%h", obs_a);
      checks++;
      if (obs_b !== exp) begin
         $display("FAIL we_gating_p5_b: got %h expected %h", obs_b, exp);
         errors++;
      end else $display("pass we_gating_p5_b obs=%h", obs_b);

      write_en = 3'b000;
      edge_n();
      checks++;
      if (obs_a !== 41'h0) begin
         $display("FAIL we_gating_none: got %h expected %h", obs_a, 41'h0);
         errors++;
      end else $display("pass we_gating_none obs=%h", obs_a);

      // Both ports selecting the same stage
      read_addr_A = 3'd5;
      read_en_A   = 1'b1;
      write_en    = 3'b101;
      edge_n();
      exp = {1'b0, 1'b1, 3'd0, 16'h1234, 1'b1, 3'd0, 16'h1234};
      checks++;
      if (obs_a !== exp) begin
         $display("FAIL same_stage_both: got %h expected %h", obs_a, exp);
         errors++;
      end else $display("pass same_stage_both obs=%h", obs_a);
   endtask

   task automatic test_load_use();
      logic [40:0] exp_stall;
      logic [40:0] exp_fwd;
      exp_stall = {1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000};
      exp_fwd   = {1'b0, 1'b1, 3'd1, 16'hAAAA, 1'b0, 3'd0, 16'h0000};
      clear_inputs();
      read_addr_A = 3'd4;
      read_en_A   = 1'b1;
      set_stage(0, 3'd4, 16'hAAAA, 1'b1);
      set_stage(1, 3'd4, 16'h5555, 1'b1);
      load_p3     = 1'b1;
      edge_n();                                   // edge N
      checks++;
      if (obs_a !== exp_stall) begin
         $display("FAIL load_use_N_a: got %h expected %h", obs_a, exp_stall);
         errors++;
      end else $display("pass load_use_N_a obs=%h", obs_a);
      checks++;
      if (obs_b !== exp_stall) begin
         $display("FAIL load_use_N_b: got %h expected %h", obs_b, exp_stall);
         errors++;
      end else $display("pass load_use_N_b obs=%h", obs_b);

      // Bubble in p3, load has moved to p4 with its data
      set_stage(0, 3'd0, 16'h0000, 1'b0);
      set_stage(1, 3'd4, 16'hAAAA, 1'b1);
      load_p3 = 1'b0;
      edge_n();                                   // edge N+1
      checks++;
      if (obs_a !== exp_stall) begin
         $display("FAIL load_use_N1_a: got %h expected %h", obs_a, exp_stall);
         errors++;
      end else $display("pass load_use_N1_a obs=%h", obs_a);

      edge_n();                                   // edge N+2
      checks++;
      if (obs_a !== exp_fwd) begin
         $display("FAIL load_use_N2_a: got %h expected %h", obs_a, exp_fwd);
         errors++;
      end else $display("pass load_use_N2_a obs=%h", obs_a);
      checks++;
      if (obs_b !== exp_stall) begin
         $display("FAIL load_use_N2_b: got %h expected %h", obs_b, exp_stall);
         errors++;
      end else $display("pass load_use_N2_b obs=%h", obs_b);

      edge_n();                                   // edge N+3
      checks++;
      if (obs_b !== exp_fwd) begin
         $display("FAIL load_use_N3_b: got %h expected %h", obs_b, exp_fwd);
         errors++;
      end else $display("pass load_use_N3_b obs=%h", obs_b);
   endtask

   task automatic test_read_en_gating();
      logic [40:0] exp;
      clear_inputs();
      read_addr_B = 3'd6;
      read_en_B   = 1'b0;
      set_stage(0, 3'd6, 16'h6666, 1'b1);
      load_p3     = 1'b1;
      edge_n();
      checks++;
      if (obs_a !== 41'h0) begin
         $display("FAIL read_en_off_a: got %h expected %h", obs_a, 41'h0);
         errors++;
      end else $display("pass read_en_off_a obs=%h", obs_a);
      checks++;
      if (obs_b !== 41'h0) begin
         $display("FAIL read_en_off_b: got %h expected %h", obs_b, 41'h0);
         errors++;
      end else $display("pass read_en_off_b obs=%h", obs_b);

      // Load in p3 to a different register: no stall, p4 forwards
      read_en_B = 1'b1;
      set_stage(0, 3'd7, 16'h6666, 1'b1);
      set_stage(1, 3'd6, 16'h7777, 1'b1);
      edge_n();
      exp = {1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h7777};
      checks++;
      if (obs_a !== exp) begin
         $display("FAIL load_nomatch_a: got %h expected %h", obs_a, exp);
         errors++;
      end else $display("pass load_nomatch_a obs=%h", obs_a);
   endtask

   task automatic test_zero_reg();
      logic [40:0] exp;
      clear_inputs();
      read_addr_A = 3'd0;
      read_en_A   = 1'b1;
      set_stage(0, 3'd0, 16'h00FF, 1'b1);
      edge_n();
      exp = {1'b0, 1'b1, 3'd0, 16'h00FF, 1'b0, 3'd0, 16'h0000};
      checks++;
      if (obs_a !== exp) begin
         $display("FAIL zero_reg_off_fwd: got %h expected %h", obs_a, exp);
         errors++;
      end else $display("pass zero_reg_off_fwd obs=%h", obs_a);
      checks++;
      if (obs_b !== 41'h0) begin
         $display("FAIL zero_reg_on_nofwd: got %h expected %h", obs_b, 41'h0);
         errors++;
      end else $display("pass zero_reg_on_nofwd obs=%h", obs_b);

      load_p3 = 1'b1;
      edge_n();
      exp = {1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000};
      checks++;
      if (obs_a !== exp) begin
         $display("FAIL zero_reg_off_stall: got %h expected %h", obs_a, exp);
         errors++;
      end else $display("pass zero_reg_off_stall obs=%h", obs_a);
      checks++;
      if (obs_b !== 41'h0) begin
         $display("FAIL zero_reg_on_nostall: got %h expected %h", obs_b, 41'h0);
         errors++;
      end else $display("pass zero_reg_on_nostall obs=%h", obs_b);

      clear_inputs();
      edge_n();
      edge_n();
      checks++;
      if (obs_a !== 41'h0) begin
         $display("FAIL zero_reg_recover: got %h expected %h", obs_a, 41'h0);
         errors++;
      end else $display("pass zero_reg_recover obs=%h", obs_a);
   endtask

   task automatic test_reset_mid_stall();
      logic [40:0] exp;
      clear_inputs();
      read_addr_A = 3'd2;
      read_en_A   = 1'b1;
      set_stage(0, 3'd2, 16'h0202, 1'b1);
      load_p3     = 1'b1;
      edge_n();
      exp = {1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000};
      checks++;
      if (obs_b !== exp) begin
         $display("FAIL midstall_enter: got %h expected %h", obs_b, exp);
         errors++;
      end else $display("pass midstall_enter obs=%h", obs_b);

      reset_n = 1'b0;
      #1;
      checks++;
      if (obs_b !== 41'h0) begin
         $display("FAIL midstall_async_b: got %h expected %h", obs_b, 41'h0);
         errors++;
      end else $display("pass midstall_async_b obs=%h", obs_b);
      checks++;
      if (obs_a !== 41'h0) begin
         $display("FAIL midstall_async_a: got %h expected %h", obs_a, 41'h0);
         errors++;
      end else $display("pass midstall_async_a obs=%h", obs_a);

      load_p3 = 1'b0;
      #2;
      reset_n = 1'b1;
      edge_n();
      exp = {1'b0, 1'b1, 3'd0, 16'h0202, 1'b0, 3'd0, 16'h0000};
      checks++;
      if (obs_b !== exp) begin
         $display("FAIL midstall_run_after: got %h expected %h", obs_b, exp);
         errors++;
      end else $display("pass midstall_run_after obs=%h", obs_b);
   endtask

   task automatic test_flush();
      logic [40:0] exp;
      clear_inputs();
      read_addr_A = 3'd2;
      read_en_A   = 1'b1;
      set_stage(0, 3'd2, 16'h0202, 1'b1);
      load_p3     = 1'b1;
      flush       = 1'b1;
      edge_n();
      checks++;
      if (obs_a !== 41'h0) begin
         $display("FAIL flush_hazard_a: got %h expected %h", obs_a, 41'h0);
         errors++;
      end else $display("pass flush_hazard_a obs=%h", obs_a);
      checks++;
      if (obs_b !== 41'h0) begin
         $display("FAIL flush_hazard_b: got %h expected %h", obs_b, 41'h0);
         errors++;
      end else $display("pass flush_hazard_b obs=%h", obs_b);

      flush = 1'b0;
      edge_n();
      exp = {1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000};
      checks++;
      if (obs_b !== exp) begin
         $display("FAIL flush_pre_stall: got %h expected %h", obs_b, exp);
         errors++;
      end else $display("pass flush_pre_stall obs=%h", obs_b);

      flush   = 1'b1;
      load_p3 = 1'b0;
      edge_n();
      checks++;
      if (obs_b !== 41'h0) begin
         $display("FAIL flush_in_stall: got %h expected %h", obs_b, 41'h0);
         errors++;
      end else $display("pass flush_in_stall obs=%h", obs_b);

      flush = 1'b0;
      edge_n();
      exp = {1'b0, 1'b1, 3'd0, 16'h0202, 1'b0, 3'd0, 16'h0000};
      checks++;
      if (obs_b !== exp) begin
         $display("FAIL flush_run_after: got %h expected %h", obs_b, exp);
         errors++;
      end else $display("pass flush_run_after obs=%h", obs_b);
   endtask

   initial begin
      reset_n = 1'b0;
      clear_inputs();
      #2;
      test_reset();
      test_defaults();
      test_we_gating();
      test_load_use();
      test_read_en_gating();
      test_zero_reg();
      test_reset_mid_stall();
      test_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/forwarding_ctrl.md
# forwarding_ctrl

Parametrised operand-forwarding and load-use stall controller for the execute pipeline. For each of two operand read ports in stage p2, it compares the read register address against the destination addresses of `STAGES` younger-to-older downstream stages (p3, p4, … p(2+STAGES)). It selects forwarded data by youngest-stage priority, gated by each stage's write enable. It also detects load-use hazards against p3 and runs a stall state machine that freezes p2 for a programmable number of cycles.

## Interface
- `DATA_W`, default 16: forwarded data width.
- `ADDR_W`, default 3: register address width.
- `STAGES`, default 3: number of downstream stages compared. Range 1..6. Index 0 = p3 (youngest).
- `LOAD_STALL`, default 1: stall cycles inserted per load-use hazard. Range 1..15.
- `ZERO_REG`, default 0: if 1, address 0 is hard-wired zero and is never forwarded or stalled on.
- `clock`  in  1  pipeline clock; all state updates on the falling edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous; abandons stall, clears outputs.
- `read_addr_A`, `read_addr_B`  in  ADDR_W  p2 operand addresses.
- `read_en_A`, `read_en_B`  in  1  operand actually used by the p2 instruction.
- `write_addr_bus`  in  STAGES*ADDR_W  destination addresses; stage i at bits [i*ADDR_W +: ADDR_W].
- `write_data_bus`  in  STAGES*DATA_W  result data; stage i at [i*DATA_W +: DATA_W].
- `write_en`  in  STAGES  stage i will write its destination.
- `load_p3`  in  1  p3 is a load; its data is not yet valid.
- `fwd_data_A`, `fwd_data_B`  out  DATA_W  forwarded operand.
- `fwd_en_A`, `fwd_en_B`  out  1  use `fwd_data_*` instead of the register file.
- `fwd_src_A`, `fwd_src_B`  out  3  index of the selected stage (0 when `fwd_en` = 0).
- `stall_p2`  out  1  hold p2 and PC, inject a bubble into p3.

## Operation
- Per port, match[i] = read_en & write_en[i] & (read_addr == write_addr[i]). If `ZERO_REG` = 1, additionally require read_addr != 0.
- Selection: the lowest i with match[i] wins, so younger data overrides older. No match gives fwd_en=0, fwd_data=0, fwd_src=0. A matching address with write_en[i]=0 is not a match, and search continues to older stages.
- Hazard = (match_A[0] | match_B[0]) & load_p3.
- FSM states: RUN and STALL, with a 4-bit counter `cnt`.
  - RUN, no hazard: outputs take the selection result, stall_p2=0.
  - RUN, hazard: go to STALL, stall_p2=1, cnt=LOAD_STALL-1, all fwd_en=0, fwd_data=0.
  - STALL, cnt!=0: cnt decrements, stall_p2=1, fwd outputs 0.
  - STALL, cnt==0: go to RUN and evaluate normally in that same edge. A fresh hazard re-enters STALL.
- flush=1, any state: next state RUN, cnt=0, all outputs 0. Flush has priority over hazard.
- Ports A and B are evaluated independently. Both may select the same stage.

## Timing
- All outputs are registered on the falling edge of `clock`. They are valid from that edge until the next falling edge and are consumed by p2 logic at the rising edge.
- Latency: inputs sampled at falling edge N appear on the outputs after edge N.
- A hazard at edge N holds stall_p2=1 for exactly LOAD_STALL falling edges (N .. N+LOAD_STALL-1). It is released at edge N+LOAD_STALL unless that edge detects a new hazard.
- Reset (reset_n=0, async, any time including mid-stall): state RUN, cnt=0, fwd_data_*=0, fwd_en_*=0, fwd_src_*=0, stall_p2=0. The first evaluation happens at the first falling edge after reset_n rises.
- load_p3 on a non-matching or disabled stage 0 never stalls. A stage-0 load match takes precedence over any older-stage match.

## Test plan
- Defaults. read_addr_A=3, write_addr p3=3 / p4=3, write_en=3'b011, data p3=0x1111 / p4=0x2222 → fwd_en_A=1, fwd_data_A=0x1111, fwd_src_A=0.
- Write-enable gating. read_addr_B=5, p3 addr=5 with write_en[0]=0, p4 addr=2, p5 addr=5 with en=1, data p5=0xBEEF → fwd_data_B=0xBEEF, fwd_src_B=2. All enables 0 → fwd_en_B=0, fwd_data_B=0.
- Load-use, LOAD_STALL=2. read_addr_A matches p3, load_p3=1 at edge N → stall_p2=1 at N and N+1 with fwd_en_A=0. At N+2, with the load now in p4 and matching, stall_p2=0, fwd_en_A=1, fwd_src_A=1.
- read_en gating. read_en_B=0, read_addr_B matches a loading p3 → no stall, fwd_en_B=0.
- ZERO_REG=1. read_addr_A=0 matching p3 with write_en=1, data 0x00FF → fwd_en_A=0.
- Reset/flush. Assert reset_n=0 during cycle 1 of a 3-cycle stall → all outputs 0 immediately and RUN after release. flush=1 with a simultaneous hazard → stall_p2=0 and fwd outputs 0 on that edge.
